fread_streamer: RTL and testbench

Turns one large file read (file id, start offset, byte count) into a sequence of chunked `fread` requests for the ESP32 fread command block, and merges the returned bytes into one backpressured byte stream with an end marker. Sits directly upstream of the fread command block when that block is built with its `FIFO` response interface:
- drives its request submit port;
- drains its response FIFO.

---
 rtl/fread_pkg.sv | 20 ++
 rtl/fread_streamer.sv | 110 +++++++++++
 tb/tb_fread_streamer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fread_pkg.sv
// Shared constants for the fread chunking streamer: state encoding,
// default chunk size and the chunk-length helper.
package fread_pkg;

  localparam int REQ_LEN_W     = 11;
  localparam int CHUNK_MAX_DEF = 512;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_RECV  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // min(rem, cmax), sized for the request length field
  function automatic logic [REQ_LEN_W-1:0] chunk_len(input logic [31:0] rem,
                                                     input int unsigned cmax);
    if (rem < 32'(cmax)) return rem[REQ_LEN_W-1:0];
    else                 return REQ_LEN_W'(cmax);
  endfunction

endpackage

// File: rtl/fread_streamer.sv
// Splits one large file read into chunked fread requests and merges the
// response FIFO bytes into a single backpressured stream with an end marker.
module fread_streamer
  import fread_pkg::*;
#(
  parameter int CHUNK_MAX = CHUNK_MAX_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          cmd_file_id,
  input  logic [31:0]          cmd_offset,
  input  logic [31:0]          cmd_len,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 abort,
  output logic [31:0]          req_file_id,
  output logic [31:0]          req_offset,
  output logic [REQ_LEN_W-1:0] req_len,
  output logic                 req_valid,
  input  logic                 req_ready,
  input  logic [7:0]           resp_data,
  input  logic                 resp_valid,
  output logic                 resp_ready,
  output logic [7:0]           out_data,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  logic [1:0]           state;
  logic [31:0]          file_id;
  logic [31:0]          offset;
  logic [31:0]          remaining;
  logic [REQ_LEN_W-1:0] chunk_cnt;

  logic in_recv, in_drain, xfer, chunk_end;

  assign in_recv   = (state == ST_RECV);
  assign in_drain  = (state == ST_DRAIN);
  assign xfer      = in_recv & resp_valid & out_ready;
  assign chunk_end = (chunk_cnt == REQ_LEN_W'(1));

  // offset only moves on the edge that leaves REQ, so it is stable as the
  // request offset for as long as req_valid is high
  assign req_file_id = file_id;
  assign req_offset  = offset;
  assign req_valid   = (state == ST_REQ);
  assign cmd_ready   = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);

  // zero-latency response pass-through; DRAIN swallows bytes unconditionally
  assign out_data   = resp_data;
  assign out_valid  = in_recv & resp_valid;
  assign resp_ready = (in_recv & out_ready) | in_drain;
  assign out_last   = out_valid & (remaining == 32'd1) & ~abort;

  // command/chunk sequencing FSM with its counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      file_id   <= '0;
      offset    <= '0;
      remaining <= '0;
      chunk_cnt <= '0;
      req_len   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            file_id   <= cmd_file_id;
            offset    <= cmd_offset;
            remaining <= cmd_len;
            req_len   <= chunk_len(cmd_len, CHUNK_MAX);
            if (cmd_len != 32'd0) state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (abort) state <= ST_IDLE;
          else if (req_ready) begin
            chunk_cnt <= req_len;
            offset    <= offset + 32'(req_len);
            state     <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (xfer) begin
            chunk_cnt <= chunk_cnt - REQ_LEN_W'(1);
            remaining <= remaining - 32'd1;
            if (chunk_end) begin
              if (abort || remaining == 32'd1) state <= ST_IDLE;
              else begin
                req_len <= chunk_len(remaining - 32'd1, CHUNK_MAX);
                state   <= ST_REQ;
              end
            end else if (abort) state <= ST_DRAIN;
          end else if (abort) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (resp_valid) begin
            chunk_cnt <= chunk_cnt - REQ_LEN_W'(1);
            if (chunk_end) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fread_streamer.sv
// Randomized bench: emulates the fread block's request port and response
// FIFO, and checks the merged stream against a chunk-list reference model.
module tb_fread_streamer;
  import fread_pkg::*;

  logic clk = 1'b0, rst_n;
  logic [31:0] cmd_file_id, cmd_offset, cmd_len;
  logic cmd_valid, cmd_ready, abort;
  logic [31:0] req_file_id, req_offset;
  logic [REQ_LEN_W-1:0] req_len;
  logic req_valid, req_ready;
  logic [7:0] resp_data;
  logic resp_valid, resp_ready;
  logic [7:0] out_data;
  logic out_last, out_valid, out_ready, busy;

  fread_streamer #(.CHUNK_MAX(512)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_file_id(cmd_file_id), .cmd_offset(cmd_offset), .cmd_len(cmd_len),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .abort(abort),
    .req_file_id(req_file_id), .req_offset(req_offset), .req_len(req_len),
    .req_valid(req_valid), .req_ready(req_ready),
    .resp_data(resp_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] off; logic [31:0] len; } req_t;

  req_t       exp_req[$];
  logic [7:0] fifo_q[$];
  logic [8:0] exp_out[$];
  int n_tests = 0, n_fail = 0;
  int chunk_left = 0, out_cnt = 0, stall = 0;
  bit nxt_req = 0, nxt_idle = 0, draining = 0, hold_req = 0;
  logic [31:0] cur_fid;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference: chunk list from plain arithmetic on the whole command
  task automatic plan(input logic [31:0] off, input logic [31:0] len);
    logic [31:0] rem, o, l;
    rem = len; o = off;
    while (rem != 0) begin
      l = (rem < 512) ? rem : 512;
      exp_req.push_back('{off: o, len: l});
      o = o + l; rem = rem - l;
    end
  endtask

  // one clock: observe handshakes mid-cycle, then drive fresh random inputs
  task automatic cycle();
    req_t r;
    logic [8:0] e;
    logic [7:0] d;
    @(negedge clk);
    if (nxt_req) begin chk("req_next", req_valid, 1); nxt_req = 0; end
    if (nxt_idle) begin
      chk("idle_next", cmd_ready, 1); chk("no_req", req_valid, 0); nxt_idle = 0;
    end
    if (out_valid) chk("rr_track", resp_ready, out_ready);
    if (draining) chk("drain_quiet", out_valid, 0);
    if (req_valid && req_ready) begin
      if (exp_req.size() == 0) chk("req_unexp", 1, 0);
      else begin
        r = exp_req.pop_front();
        chk("req_off", req_offset, r.off);
        chk("req_len", 32'(req_len), r.len);
        chk("req_fid", req_file_id, cur_fid);
        chunk_left = int'(r.len);
        for (int i = 0; i < int'(r.len); i++) begin
          d = 8'($urandom);
          fifo_q.push_back(d);
          exp_out.push_back({(exp_req.size() == 0 && i == int'(r.len) - 1), d});
        end
      end
    end
    if (out_valid && out_ready) begin
      out_cnt++;
      if (exp_out.size() == 0) chk("out_unexp", 1, 0);
      else begin
        e = exp_out.pop_front();
        chk("out_data", 32'(out_data), 32'(e[7:0]));
        chk("out_last", 32'(out_last), 32'(e[8]));
      end
      if (chunk_left > 0) begin
        chunk_left--;
        if (chunk_left == 0) begin
          if (exp_req.size() > 0) nxt_req = 1; else nxt_idle = 1;
        end
      end
    end
    if (resp_valid && resp_ready && fifo_q.size() > 0) void'(fifo_q.pop_front());
    @(posedge clk); #1;
    req_ready = hold_req ? 1'b0 : ($urandom_range(0, 2) == 0);
    if (stall > 0) begin out_ready = 1'b0; stall--; end
    else begin
      out_ready = 1'b1;
      if ($urandom_range(0, 3) == 0) stall = $urandom_range(1, 5);
    end
    resp_valid = (fifo_q.size() > 0) && ($urandom_range(0, 7) != 0);
    resp_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic accept(input logic [31:0] fid, input logic [31:0] off, input logic [31:0] len);
    cur_fid = fid;
    plan(off, len);
    chk("cmd_rdy", cmd_ready, 1);
    cmd_file_id = fid; cmd_offset = off; cmd_len = len; cmd_valid = 1'b1;
    cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [31:0] fid, input logic [31:0] off, input logic [31:0] len);
    int c;
    accept(fid, off, len);
    if (len != 0) nxt_req = 1; else nxt_idle = 1;
    for (c = 0; c < 20000; c++) begin
      if (!busy && !nxt_req && !nxt_idle && exp_req.size() == 0 &&
          exp_out.size() == 0 && fifo_q.size() == 0) break;
      cycle();
    end
    chk("cmd_timeout", (c < 20000) ? 1 : 0, 1);
    chk("out_left", exp_out.size(), 0);
    chk("busy_end", busy, 0);
  endtask

  initial begin
    int c;
    rst_n = 1'b0; cmd_valid = 0; abort = 0; req_ready = 0; resp_valid = 0;
    resp_data = 0; out_ready = 0; cmd_file_id = 0; cmd_offset = 0; cmd_len = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_resp_ready", resp_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_req_fields", req_file_id | req_offset | 32'(req_len), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_cmd(32'h0000_00A5, 32'h0000_1000, 100);
    run_cmd(32'h0000_0042, 32'h0000_0000, 1300);
    run_cmd(32'h0000_0007, 32'hFFFF_FF00, 600);
    run_cmd(32'h0000_0009, 32'h0000_0000, 0);

    // abort while the request is pending: request drops, back to idle
    hold_req = 1;
    accept(32'h0000_0011, 32'h0000_2000, 50);
    chk("req_up", req_valid, 1);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("req_drop", req_valid, 0);
    chk("req_abort_idle", busy, 0);
    exp_req.delete();
    hold_req = 0;

    // abort after 10 bytes of a 512-byte chunk: remaining bytes get drained
    out_cnt = 0;
    accept(32'h0000_0033, 32'h0000_4000, 1000);
    for (c = 0; c < 5000 && out_cnt < 10; c++) cycle();
    chk("abort_reach10", out_cnt, 10);
    abort = 1'b1; out_ready = 1'b0;
    cycle();
    abort = 1'b0;
    exp_out.delete(); exp_req.delete();
    chunk_left = 0; nxt_req = 0; nxt_idle = 0;
    draining = 1;
    chk("drain_cnt", fifo_q.size(), 502);
    for (c = 0; c < 20000 && fifo_q.size() > 0; c++) cycle();
    chk("drain_empty", fifo_q.size(), 0);
    chk("abort_idle", busy, 0);
    draining = 0;

    run_cmd(32'h0000_0055, 32'h0000_8000, 300);
    for (int k = 0; k < 5; k++)
      run_cmd($urandom, $urandom, $urandom_range(1, 1500));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
